prm_obstacle_scan_ctrl: RTL and testbench
=========================================

// Module: prm_obstacle_scan_ctrl
// PURPOSE
// Feeds obstacle voxel codes to the bank of prm_oblgc_chk* edge checkers and collects their edge_mask bits.
// Codes stream in one per cycle; each edge's result is OR-ed into a blocked-edge bitmap.
// After the last code, the bitmap is returned as OUT_W-bit words for roadmap pruning.
// The block sits between the obstacle source and the roadmap planner.
// PARAMETERS
// CODE_W     15    obstacle code width; bit order {O..A} = chk_code[14:0]
// NUM_EDGES  1024  number of checker instances / bitmap bits; must be a multiple of OUT_W
// OUT_W      32    readout word width
// CNT_W      16    obstacle counter width
// PORTS
// clk        in   1          single clock, rising edge
// rst        in   1          asynchronous, active-high reset
// start      in   1          one-cycle pulse; clears bitmap and begins a scan (honoured in IDLE only)
// obs_valid  in   1          obstacle code valid
// obs_ready  out  1          obstacle code accepted when valid&ready
// obs_code   in   CODE_W     obstacle voxel code
// obs_last   in   1          marks the final code of the scan
// chk_code   out  CODE_W     registered code driven to all checker inputs
// chk_valid  out  1          chk_code holds a live code this cycle
// chk_mask   in   NUM_EDGES  edge_mask outputs of the checker bank; combinational from chk_code
// out_valid  out  1          readout word valid
// out_ready  in   1          readout word consumed when valid&ready
// out_data   out  OUT_W      bitmap word; word k = bits [k*OUT_W +: OUT_W]
// out_last   out  1          high with the final word
// busy       out  1          high in every state except IDLE
// obs_count  out  CNT_W      codes accepted this scan; saturates at all-ones
// BEHAVIOUR
// - Reset value of every output and register is 0; state returns to IDLE. Reset mid-scan or mid-readout aborts with no output.
// - FSM states and transitions:
//   - IDLE -> SCAN on start. Start clears the bitmap and obs_count.
//   - SCAN -> DRAIN on an accepted code with obs_last=1.
//   - DRAIN -> EMIT after exactly 1 cycle.
//   - EMIT -> IDLE on acceptance of the last word.
// - obs_ready = (state==SCAN); it is combinational, with no skid buffer.
// - Pipeline for a code accepted in cycle t:
//   - chk_code and chk_valid are registered at t+1.
//   - At the end of t+1, if chk_valid, bitmap |= chk_mask.
//   - The bitmap reflects that code from t+2.
// - chk_valid returns to 0 in the cycle after an idle or non-accepting cycle. chk_code holds its last value.
// - The DRAIN cycle lets the last code's chk_mask be folded in before readout starts.
// - EMIT:
//   - out_valid stays high for the whole state.
//   - The word index starts at 0 and increments on each handshake.
//   - out_data and out_last are held stable while out_ready is low.
//   - out_last = (index == NUM_EDGES/OUT_W-1).
// - The bitmap is frozen outside SCAN and DRAIN. Start pulses outside IDLE are ignored.
// - obs_valid outside SCAN is ignored. obs_code and obs_last are sampled only on a handshake.
// - obs_count increments per accepted code and saturates with no wrap. The bitmap OR is idempotent, so duplicate codes are harmless.
// - A scan always contains at least one code; obs_last on the first code yields a 1-code scan.
// - Scan latency: first word is valid 2 cycles after the obs_last handshake.
// STRUCTURE
// - Package prm_scan_pkg holds CODE_W, the default NUM_EDGES and OUT_W, and typedef enum {IDLE,SCAN,DRAIN,EMIT} scan_state_t.
// - Sub-module prm_edge_serializer holds the word index counter, the NUM_EDGES->OUT_W word mux, out_valid/out_last and the handshake.
// - Top level holds the FSM, the code pipeline register, the bitmap accumulator and obs_count.
// - The checker bank is instantiated outside this block.
// TESTING
// Bench model of the checker bank: chk_mask[e] = (chk_code[9:0]==e) | (chk_code==15'h7FFF). Use NUM_EDGES=1024, OUT_W=32.
// 1. start; codes 5, 37, 1023(last), back-to-back, out_ready=1 -> 32 words. Word0=0x00000020, word1=0x00000020, word31=0x80000000 with out_last. obs_count=3.
// 2. start; single code 15'h7FFF with obs_last -> all 32 words are 0xFFFFFFFF. First out_valid comes 2 cycles after the handshake.
// 3. obs_valid toggling every other cycle; codes 0, 0, 64(last) -> word0=0x00000001, word2=0x00000001, all others 0. chk_valid drops on gap cycles.
// 4. out_ready low for 5 cycles at word 3 -> out_data and out_last are held unchanged, the index does not advance, and all 32 words arrive in order.
// 5. Assert rst during SCAN after 2 codes, then start a new scan with code 100(last) -> only bit 100 is set (word3=0x00000010), and obs_count=1.
// 6. start pulsed during EMIT, and obs_valid asserted in IDLE -> both are ignored: obs_ready=0, busy stays 1 through EMIT, and the readout is unchanged.

Source files
------------

// File: rtl/prm_scan_pkg.sv
// Shared types and default sizes for the obstacle scan controller.
package prm_scan_pkg;
  localparam int CODE_W        = 15;
  localparam int NUM_EDGES_DEF = 1024;
  localparam int OUT_W_DEF     = 32;
  localparam int CNT_W_DEF     = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    EMIT  = 2'd3
  } scan_state_t;
endpackage

// File: rtl/prm_edge_serializer.sv
// Streams the frozen blocked-edge bitmap out as OUT_W-bit words with a valid/ready handshake.
module prm_edge_serializer
  import prm_scan_pkg::*;
#(
  parameter int NUM_EDGES = NUM_EDGES_DEF,
  parameter int OUT_W     = OUT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 emit_i,
  input  logic [NUM_EDGES-1:0] bitmap_i,
  input  logic                 out_ready_i,
  output logic                 out_valid_o,
  output logic [OUT_W-1:0]     out_data_o,
  output logic                 out_last_o,
  output logic                 done_o
);
  localparam int NUM_WORDS = NUM_EDGES / OUT_W;
  localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  logic [NUM_WORDS-1:0][OUT_W-1:0] words;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic                            hs;

  assign words       = bitmap_i;
  assign out_valid_o = emit_i;
  assign out_data_o  = words[idx_q];
  assign out_last_o  = emit_i && (idx_q == IDX_W'(NUM_WORDS - 1));
  assign hs          = emit_i && out_ready_i;
  assign done_o      = hs && out_last_o;

  // Index parks at 0 outside EMIT so every readout starts at word 0.
  always_comb begin
    idx_d = idx_q;
    if (!emit_i)     idx_d = '0;
    else if (done_o) idx_d = '0;
    else if (hs)     idx_d = idx_q + IDX_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) idx_q <= '0;
    else     idx_q <= idx_d;
  end
endmodule

// File: rtl/prm_obstacle_scan_ctrl.sv
// Streams obstacle codes to the edge-checker bank, ORs their edge masks into a bitmap, then reads it out.
module prm_obstacle_scan_ctrl
  import prm_scan_pkg::*;
#(
  parameter int NUM_EDGES = NUM_EDGES_DEF,
  parameter int OUT_W     = OUT_W_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 obs_valid,
  output logic                 obs_ready,
  input  logic [CODE_W-1:0]    obs_code,
  input  logic                 obs_last,
  output logic [CODE_W-1:0]    chk_code,
  output logic                 chk_valid,
  input  logic [NUM_EDGES-1:0] chk_mask,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_W-1:0]     out_data,
  output logic                 out_last,
  output logic                 busy,
  output logic [CNT_W-1:0]     obs_count
);
  scan_state_t            state_q, state_d;
  logic [CODE_W-1:0]      chk_code_q, chk_code_d;
  logic                   chk_valid_q, chk_valid_d;
  logic [NUM_EDGES-1:0]   bitmap_q, bitmap_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   accept;
  logic                   emit_done;

  assign obs_ready = (state_q == SCAN);
  assign accept    = obs_valid && obs_ready;
  assign busy      = (state_q != IDLE);
  assign chk_code  = chk_code_q;
  assign chk_valid = chk_valid_q;
  assign obs_count = count_q;

  // NOTE: every always_comb output gets its default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SCAN;
      SCAN:    if (accept && obs_last) state_d = DRAIN;
      DRAIN:   state_d = EMIT;
      EMIT:    if (emit_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The mask for a code arrives one cycle after acceptance; DRAIN exists to fold in the last one.
  always_comb begin
    chk_valid_d = accept;
    chk_code_d  = accept ? obs_code : chk_code_q;
    bitmap_d    = bitmap_q;
    count_d     = count_q;
    if (state_q == IDLE && start) begin
      bitmap_d = '0;
      count_d  = '0;
    end else begin
      if ((state_q == SCAN || state_q == DRAIN) && chk_valid_q)
        bitmap_d = bitmap_q | chk_mask;
      if (accept && count_q != '1)
        count_d = count_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the bitmap is a plain register and is reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      chk_code_q  <= '0;
      chk_valid_q <= 1'b0;
      bitmap_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      chk_code_q  <= chk_code_d;
      chk_valid_q <= chk_valid_d;
      bitmap_q    <= bitmap_d;
      count_q     <= count_d;
    end
  end

  prm_edge_serializer #(
    .NUM_EDGES (NUM_EDGES),
    .OUT_W     (OUT_W)
  ) u_serializer (
    .clk         (clk),
    .rst         (rst),
    .emit_i      (state_q == EMIT),
    .bitmap_i    (bitmap_q),
    .out_ready_i (out_ready),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_last_o  (out_last),
    .done_o      (emit_done)
  );
endmodule

// File: tb/tb_prm_obstacle_scan_ctrl.sv
// Self-checking bench: behavioural scan model compared every cycle, plus literal per-scenario expectations.
module tb_prm_obstacle_scan_ctrl;
  localparam int NE = 1024;
  localparam int OW = 32;
  localparam int NW = NE / OW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          obs_valid = 1'b0;
  logic          obs_ready;
  logic [14:0]   obs_code = '0;
  logic          obs_last = 1'b0;
  logic [14:0]   chk_code;
  logic          chk_valid;
  logic [NE-1:0] chk_mask;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [OW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic [15:0]   obs_count;

  int n_checks = 0;
  int n_errors = 0;

  prm_obstacle_scan_ctrl #(.NUM_EDGES(NE), .OUT_W(OW), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .obs_valid(obs_valid), .obs_ready(obs_ready),
    .obs_code(obs_code), .obs_last(obs_last), .chk_code(chk_code), .chk_valid(chk_valid),
    .chk_mask(chk_mask), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .obs_count(obs_count)
  );

  always #5 clk = ~clk;

  // Checker bank stand-in: edge e is blocked by code e (low 10 bits) or by the all-ones code.
  always_comb begin
    chk_mask = '0;
    for (int e = 0; e < NE; e++)
      chk_mask[e] = (chk_code[9:0] == 10'(e)) || (chk_code == 15'h7FFF);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_phase;          // 0 idle, 1 scanning, 2 drain, 3 readout
  logic [14:0] m_codes[$];
  int          m_count;
  int          m_word;
  logic        m_chk_valid;
  logic [14:0] m_chk_code;

  function automatic logic [31:0] exp_word(input int k);
    logic [31:0] w = '0;
    for (int b = 0; b < OW; b++)
      foreach (m_codes[i])
        if (int'(m_codes[i][9:0]) == k * OW + b || m_codes[i] == 15'h7FFF) w[b] = 1'b1;
    return w;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0; m_codes.delete(); m_count = 0; m_word = 0;
      m_chk_valid = 1'b0; m_chk_code = '0;
    end else begin
      m_chk_valid = 1'b0;
      case (m_phase)
        0: if (start) begin m_codes.delete(); m_count = 0; m_phase = 1; end
        1: if (obs_valid) begin
             m_codes.push_back(obs_code);
             if (m_count < 65535) m_count++;
             m_chk_valid = 1'b1;
             m_chk_code  = obs_code;
             if (obs_last) m_phase = 2;
           end
        2: m_phase = 3;
        default: if (out_ready) begin
             if (m_word == NW - 1) begin m_word = 0; m_phase = 0; end
             else m_word++;
           end
      endcase
    end
  end

  bit check_en = 1'b0;
  always @(negedge clk) begin
    if (!rst && check_en) begin
      check("obs_ready", 32'(obs_ready), 32'(m_phase == 1));
      check("busy", 32'(busy), 32'(m_phase != 0));
      check("obs_count", 32'(obs_count), 32'(m_count));
      check("chk_valid", 32'(chk_valid), 32'(m_chk_valid));
      check("chk_code", 32'(chk_code), 32'(m_chk_code));
      check("out_valid", 32'(out_valid), 32'(m_phase == 3));
      if (m_phase == 3) begin
        check("out_data", out_data, exp_word(m_word));
        check("out_last", 32'(out_last), 32'(m_word == NW - 1));
      end
    end
  end

  // ---------------- capture of readout words and latency ----------------
  logic [31:0] cap_words[NW];
  logic        cap_last[NW];
  int          cap_n = 0;
  int          cyc = 0;
  int          hs_cyc = 0;
  int          first_ov = -1;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (start && !busy) begin cap_n = 0; first_ov = -1; end
    if (obs_valid && obs_ready && obs_last) hs_cyc = cyc;
    if (out_valid && first_ov < 0) first_ov = cyc;
    if (out_valid && out_ready && cap_n < NW) begin
      cap_words[cap_n] = out_data;
      cap_last[cap_n]  = out_last;
      cap_n++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic send_code(input logic [14:0] c, input logic l);
    bit done = 1'b0;
    obs_valid = 1'b1; obs_code = c; obs_last = l;
    for (int n = 0; n < 20 && !done; n++) begin
      if (obs_ready) done = 1'b1;
      tick();
    end
    if (!done) check("send_timeout", 32'd1, 32'd0);
    if (l) obs_valid = 1'b0;
  endtask

  task automatic readout(input int stall_at, input int stall_len, input logic [31:0] stall_exp);
    int  k = 0;
    int  stalled = 0;
    bit  fin = 1'b0;
    for (int n = 0; n < 400 && !fin; n++) begin
      if (out_valid) begin
        out_ready = !(k == stall_at && stalled < stall_len);
        if (!out_ready) begin
          stalled++;
          check("stall_data", out_data, stall_exp);
          check("stall_last", 32'(out_last), 32'd0);
        end else begin
          if (out_last) fin = 1'b1;
          k++;
        end
      end
      tick();
    end
    out_ready = 1'b1;
    if (!fin) check("readout_timeout", 32'd1, 32'd0);
    check("word_count", 32'(cap_n), 32'(NW));
  endtask

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_obs_count", 32'(obs_count), 32'd0);
    check("rst_chk_valid", 32'(chk_valid), 32'd0);
    check("rst_chk_code", 32'(chk_code), 32'd0);
    check("rst_obs_ready", 32'(obs_ready), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check_en = 1'b1;

    // 1: back-to-back codes
    do_start();
    send_code(15'd5, 1'b0);
    send_code(15'd37, 1'b0);
    send_code(15'd1023, 1'b1);
    readout(-1, 0, 32'd0);
    check("t1_word0", cap_words[0], 32'h0000_0020);
    check("t1_word1", cap_words[1], 32'h0000_0020);
    check("t1_word31", cap_words[31], 32'h8000_0000);
    check("t1_last31", 32'(cap_last[31]), 32'd1);
    check("t1_last30", 32'(cap_last[30]), 32'd0);
    check("t1_count", 32'(obs_count), 32'd3);

    // 2: all-ones code blocks every edge
    do_start();
    send_code(15'h7FFF, 1'b1);
    readout(-1, 0, 32'd0);
    for (int i = 0; i < NW; i++) check("t2_word", cap_words[i], 32'hFFFF_FFFF);
    check("t2_latency", 32'(first_ov - hs_cyc), 32'd2);

    // 3: gaps between codes, duplicate code
    do_start();
    send_code(15'd0, 1'b0); obs_valid = 1'b0; tick();
    send_code(15'd0, 1'b0); obs_valid = 1'b0; tick();
    send_code(15'd64, 1'b1);
    readout(-1, 0, 32'd0);
    check("t3_word0", cap_words[0], 32'h0000_0001);
    check("t3_word1", cap_words[1], 32'h0000_0000);
    check("t3_word2", cap_words[2], 32'h0000_0001);
    check("t3_word31", cap_words[31], 32'h0000_0000);
    check("t3_count", 32'(obs_count), 32'd3);

    // 4: back-pressure at word 3
    do_start();
    send_code(15'd100, 1'b0);
    send_code(15'd7, 1'b1);
    readout(3, 5, 32'h0000_0010);
    check("t4_word0", cap_words[0], 32'h0000_0080);
    check("t4_word3", cap_words[3], 32'h0000_0010);
    check("t4_word4", cap_words[4], 32'h0000_0000);
    check("t4_last31", 32'(cap_last[31]), 32'd1);

    // 5: reset mid-scan aborts, next scan starts clean
    do_start();
    send_code(15'd11, 1'b0);
    send_code(15'd12, 1'b0);
    obs_valid = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0; tick();
    check("t5_busy_after_rst", 32'(busy), 32'd0);
    check("t5_count_after_rst", 32'(obs_count), 32'd0);
    check("t5_out_valid_after_rst", 32'(out_valid), 32'd0);
    do_start();
    send_code(15'd100, 1'b1);
    readout(-1, 0, 32'd0);
    check("t5_word0", cap_words[0], 32'h0000_0000);
    check("t5_word3", cap_words[3], 32'h0000_0010);
    check("t5_count", 32'(obs_count), 32'd1);

    // 6: obs_valid in IDLE and start during EMIT are ignored
    obs_valid = 1'b1; obs_code = 15'd5; obs_last = 1'b0;
    tick();
    check("t6_idle_ready", 32'(obs_ready), 32'd0);
    tick();
    obs_valid = 1'b0;
    do_start();
    out_ready = 1'b0;
    send_code(15'd200, 1'b1);
    tick();
    check("t6_emit_valid", 32'(out_valid), 32'd1);
    start = 1'b1; tick(); start = 1'b0;
    check("t6_busy", 32'(busy), 32'd1);
    check("t6_still_emit", 32'(out_valid), 32'd1);
    readout(-1, 0, 32'd0);
    check("t6_word0", cap_words[0], 32'h0000_0000);
    check("t6_word6", cap_words[6], 32'h0000_0100);
    check("t6_count", 32'(obs_count), 32'd1);
    tick();
    check("t6_idle_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
